// File: rtl/sipo_pkg.sv
// sipo_pkg: shared constants and FSM state type for the serial-to-parallel receiver
package sipo_pkg;
    localparam int WIDTH_DEF = 12;
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/sipo_out_stage.sv
// sipo_out_stage: one-word valid/ready holding register with sticky overrun flag
// Ports: i_load/i_word  completed word from the shifter
//        i_ready        consumer accepts o_data while o_valid
//        i_clr_overrun  synchronous clear of o_overrun (a same-cycle drop wins)
//        o_data/o_valid held word and its valid flag; o_overrun sticky drop flag
module sipo_out_stage #(
    parameter int WIDTH = sipo_pkg::WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_ready,
    input  logic             i_clr_overrun,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_overrun
);
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             w_room;
    // the register can take a new word if empty or being drained this very cycle
    assign w_room = !r_valid || i_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_load && w_room) begin
                r_data  <= i_word;
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
            if (i_load && !w_room)
                r_overrun <= 1'b1;
            else if (i_clr_overrun)
                r_overrun <= 1'b0;
        end
    end
    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;
endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: LSB-first serial receiver framed by sync, with valid/ready word output
// Ports: sync/bit_en/serial_in  serial link (sync restarts a word, bit_en qualifies a bit)
//        parallel_out/out_valid/out_ready  parallel handshake to the consumer
//        overrun/clr_overrun  sticky dropped-word flag and its clear
//        busy/bit_count       FSM in SHIFT and live count of bits in the current word
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             bit_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             clr_overrun,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count
);
    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             w_shift_en;
    logic             w_last;
    logic             w_done;
    logic [WIDTH-1:0] w_word;
    assign w_shift_en = (r_state == SHIFT) && bit_en && !sync;
    assign w_last     = r_cnt == CNT_W'(WIDTH - 1);
    assign w_done     = w_shift_en && w_last;
    assign w_word     = {serial_in, r_shift[WIDTH-1:1]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (sync) begin
            // restart framing; any partial word is silently abandoned
            r_state <= SHIFT;
            r_cnt   <= '0;
        end else if (w_shift_en) begin
            r_shift <= w_word;
            r_state <= w_last ? IDLE : SHIFT;
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
        end
    end
    sipo_out_stage #(.WIDTH(WIDTH)) u_out (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (w_done),
        .i_word        (w_word),
        .i_ready       (out_ready),
        .i_clr_overrun (clr_overrun),
        .o_data        (parallel_out),
        .o_valid       (out_valid),
        .o_overrun     (overrun)
    );
    assign busy      = r_state == SHIFT;
    assign bit_count = r_cnt;
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed plus random stimulus against a word-level reference model
module tb_sipo_deserializer;
    localparam int W = 12;
    localparam int CW = 4;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sync = 1'b0;
    logic          bit_en = 1'b0;
    logic          serial_in = 1'b0;
    logic          out_ready = 1'b0;
    logic          clr_overrun = 1'b0;
    logic [W-1:0]  parallel_out;
    logic          out_valid;
    logic          overrun;
    logic          busy;
    logic [CW-1:0] bit_count;
    int n_cmp = 0;
    int n_bad = 0;
    // reference model: a word is a count of received bits and an accumulated value
    bit m_active;
    int m_cnt;
    int m_acc;
    int m_pout;
    bit m_valid;
    bit m_ovr;
    sipo_deserializer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sync         (sync),
        .bit_en       (bit_en),
        .serial_in    (serial_in),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun),
        .busy         (busy),
        .bit_count    (bit_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_active = 0;
        m_cnt = 0;
        m_acc = 0;
        m_pout = 0;
        m_valid = 0;
        m_ovr = 0;
    endtask
    task automatic model_step();
        bit done;
        bit set_ovr;
        done = 0;
        set_ovr = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (sync) begin
            m_active = 1;
            m_cnt = 0;
            m_acc = 0;
        end else if (m_active && bit_en) begin
            m_acc = m_acc + (int'(serial_in) << m_cnt);
            m_cnt++;
            if (m_cnt == W) begin
                done = 1;
                if (!m_valid || out_ready) begin
                    m_pout = m_acc;
                    m_valid = 1;
                end else begin
                    set_ovr = 1;
                end
                m_active = 0;
                m_cnt = 0;
                m_acc = 0;
            end
        end
        if (!done && m_valid && out_ready) m_valid = 0;
        if (set_ovr) m_ovr = 1;
        else if (clr_overrun) m_ovr = 0;
    endtask
    task automatic check_model();
        chk("parallel_out", int'(parallel_out), m_pout);
        chk("out_valid", int'(out_valid), int'(m_valid));
        chk("overrun", int'(overrun), int'(m_ovr));
        chk("busy", int'(busy), int'(m_active));
        chk("bit_count", int'(bit_count), m_cnt);
    endtask
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask
    task automatic send_bit(input logic b, input int maxgap);
        int g;
        g = maxgap > 0 ? int'($urandom_range(maxgap, 0)) : 0;
        bit_en = 1'b0;
        for (int k = 0; k < g; k++) tick();
        bit_en = 1'b1;
        serial_in = b;
        tick();
        bit_en = 1'b0;
    endtask
    task automatic send_word(input logic [W-1:0] v, input int maxgap, input bit rdy_on_last);
        logic saved;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) begin
                saved = out_ready;
                if (rdy_on_last) out_ready = 1'b1;
                send_bit(v[i], maxgap);
                out_ready = saved;
            end else begin
                send_bit(v[i], maxgap);
            end
        end
    endtask
    initial begin
        model_reset();
        tick();
        tick();
        chk("rst_pout", int'(parallel_out), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(bit_count), 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        // basic word
        send_word(12'hA5C, 0, 1'b0);
        chk("basic_pout", int'(parallel_out), 'hA5C);
        chk("basic_valid", int'(out_valid), 1);
        chk("basic_busy", int'(busy), 0);
        chk("basic_ovr", int'(overrun), 0);
        tick();
        // gapped bits
        send_word(12'h3F1, 5, 1'b0);
        chk("gap_pout", int'(parallel_out), 'h3F1);
        chk("gap_valid", int'(out_valid), 1);
        tick();
        // resync after junk
        sync = 1'b1;
        tick();
        sync = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 0);
        chk("junk_count", int'(bit_count), 5);
        send_word(12'h800, 1, 1'b0);
        chk("resync_pout", int'(parallel_out), 'h800);
        chk("resync_ovr", int'(overrun), 0);
        tick();
        // back-pressure
        out_ready = 1'b0;
        send_word(12'h111, 0, 1'b0);
        send_word(12'h222, 2, 1'b0);
        chk("bp_pout", int'(parallel_out), 'h111);
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_ovr", int'(overrun), 1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("clr_ovr", int'(overrun), 0);
        // same-cycle accept and complete
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send_word(12'h0AA, 0, 1'b0);
        chk("hold_pout", int'(parallel_out), 'h0AA);
        send_word(12'h155, 0, 1'b1);
        chk("acc_pout", int'(parallel_out), 'h155);
        chk("acc_valid", int'(out_valid), 1);
        chk("acc_ovr", int'(overrun), 0);
        // reset mid-word
        sync = 1'b1;
        tick();
        sync = 1'b0;
        for (int i = 0; i < 7; i++) send_bit(1'($urandom), 0);
        rst_n = 1'b0;
        #1;
        chk("arst_pout", int'(parallel_out), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_count", int'(bit_count), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        chk("nosync_count", int'(bit_count), 0);
        chk("nosync_valid", int'(out_valid), 0);
        // random traffic
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom % 900) != 0;
            sync = ($urandom % 30) == 0;
            bit_en = ($urandom % 3) != 0;
            serial_in = 1'($urandom);
            out_ready = ($urandom % 3) == 0;
            clr_overrun = ($urandom % 40) == 0;
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
